// File: rtl/hog_pkg.sv
// hog_pkg: constants and types shared by the HOG cell-histogram and block-normalisation stages
package hog_pkg;
   localparam int NBINS = 9;
   localparam int HIST_W_DEF = 16;
   localparam logic [11:0] TAN_Q8 [4] = '{12'd93, 12'd215, 12'd443, 12'd1452};
   typedef logic [3:0] bin_t;
   typedef logic [NBINS-1:0][HIST_W_DEF-1:0] hist_t;
endpackage

// File: rtl/hog_cell_hist_if.sv
// hog_cell_hist_if: pixel-neighbourhood input beats and cell-histogram output bundle
interface hog_cell_hist_if
   import hog_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int HIST_W   = 16
);
   logic                      in_valid;
   logic                      in_sof;
   logic [9*BITWIDTH-1:0]     block0;
   logic [9*BITWIDTH-1:0]     block1;
   logic [9*BITWIDTH-1:0]     block2;
   logic [9*BITWIDTH-1:0]     block3;
   logic                      out_valid;
   logic [NBINS*HIST_W-1:0]   hist_out;
   logic [4:0]                cell_col;
   logic [4:0]                cell_row;
   logic                      frame_done;
   modport master (
      output in_valid, in_sof, block0, block1, block2, block3,
      input  out_valid, hist_out, cell_col, cell_row, frame_done
   );
   modport slave (
      input  in_valid, in_sof, block0, block1, block2, block3,
      output out_valid, hist_out, cell_col, cell_row, frame_done
   );
endinterface

// File: rtl/hog_grad_bin.sv
// hog_grad_bin: gradient of one 3x3 neighbourhood, then magnitude and 9-bin unsigned orientation
module hog_grad_bin
   import hog_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic [9*BITWIDTH-1:0]  blk_i,
   output logic signed [BITWIDTH:0] gx_o,
   output logic signed [BITWIDTH:0] gy_o,
   input  logic signed [BITWIDTH:0] gx_i,
   input  logic signed [BITWIDTH:0] gy_i,
   output logic [BITWIDTH:0]      mag_o,
   output bin_t                   bin_o
);
   localparam int PW = BITWIDTH + 12;
   logic [BITWIDTH:0] ax, ay;
   logic fneg, unused_blk;
   bin_t b0;
   assign unused_blk = ^blk_i;
   assign gx_o = $signed({1'b0, blk_i[5*BITWIDTH +: BITWIDTH]}) - $signed({1'b0, blk_i[3*BITWIDTH +: BITWIDTH]});
   assign gy_o = $signed({1'b0, blk_i[7*BITWIDTH +: BITWIDTH]}) - $signed({1'b0, blk_i[1*BITWIDTH +: BITWIDTH]});
   assign ax = gx_i[BITWIDTH] ? -gx_i : gx_i;
   assign ay = gy_i[BITWIDTH] ? -gy_i : gy_i;
   assign mag_o = ax + ay;
   // sign of gx after folding into the upper half-plane
   assign fneg = gy_i[BITWIDTH] ? (gx_i != '0 && !gx_i[BITWIDTH]) : gx_i[BITWIDTH];
   always_comb begin
      b0 = '0;
      for (int i = 0; i < 4; i++)
         b0 = b0 + bin_t'((PW'(ay) << 8) >= PW'(TAN_Q8[i]) * PW'(ax));
      bin_o = (ax == '0 && ay == '0) ? '0 : fneg ? bin_t'(4'd8 - b0) : b0;
   end
endmodule

// File: rtl/hog_cell_hist.sv
// hog_cell_hist: 3-stage gradient/orientation pipeline accumulating 8x8-pixel cell histograms
module hog_cell_hist
   import hog_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int COL_BEATS = 52,
   parameter int CELL_ROWS = 8,
   parameter int IMG_ROWS  = 160,
   parameter int HIST_W    = 16
) (
   input logic clk,
   input logic rst_n,
   hog_cell_hist_if.slave bus
);
   localparam int BTW  = $clog2(COL_BEATS);
   localparam int SW   = CELL_ROWS > 1 ? $clog2(CELL_ROWS) : 1;
   localparam int NC   = COL_BEATS / 2;
   localparam int AW   = BITWIDTH + 3;
   localparam int SUMW = HIST_W + 1;
   typedef logic signed [BITWIDTH:0] grad_t;
   typedef logic [NBINS-1:0][HIST_W-1:0] hist_w_t;

   logic sof_c, eol_c, eoc_c, eof_c, done_c, last_c, emit_c;
   logic [BTW-1:0] beat_c, beat_d, beat_q;
   logic [SW-1:0] sub_c, sub_d, sub_q;
   logic [4:0] crow_c, crow_d, crow_q;
   logic [9*BITWIDTH-1:0] blk_c [4];
   grad_t gx_c [4], gy_c [4], s1_gx_q [4], s1_gy_q [4];
   logic [BITWIDTH:0] mag_c [4], s2_mag_q [4];
   bin_t bin_c [4], s2_bin_q [4];
   logic s1_v_q, s1_done_q, s1_last_q, s2_v_q, s2_done_q, s2_last_q;
   logic [4:0] s1_col_q, s1_row_q, s2_col_q, s2_row_q;
   logic [AW-1:0] add_c [NBINS];
   logic [SUMW-1:0] sum_c [NBINS];
   hist_w_t new_c, hist_q;
   logic [NC-1:0][NBINS-1:0][HIST_W-1:0] acc_q;
   logic ov_q, fd_q;
   logic [4:0] ocol_q, orow_q;

   assign blk_c[0] = bus.block0;
   assign blk_c[1] = bus.block1;
   assign blk_c[2] = bus.block2;
   assign blk_c[3] = bus.block3;

   for (genvar i = 0; i < 4; i++) begin : g_px
      hog_grad_bin #(.BITWIDTH(BITWIDTH)) u_gb (
         .blk_i(blk_c[i]),
         .gx_o (gx_c[i]),
         .gy_o (gy_c[i]),
         .gx_i (s1_gx_q[i]),
         .gy_i (s1_gy_q[i]),
         .mag_o(mag_c[i]),
         .bin_o(bin_c[i])
      );
   end

   // position of the beat currently on the input; in_sof pins it to the frame origin
   always_comb begin
      sof_c  = bus.in_valid && bus.in_sof;
      beat_c = bus.in_sof ? '0 : beat_q;
      sub_c  = bus.in_sof ? '0 : sub_q;
      crow_c = bus.in_sof ? '0 : crow_q;
      eol_c  = beat_c == BTW'(COL_BEATS - 1);
      eoc_c  = sub_c == SW'(CELL_ROWS - 1);
      eof_c  = crow_c == 5'(IMG_ROWS / CELL_ROWS - 1);
      beat_d = eol_c ? '0 : beat_c + 1'b1;
      sub_d  = !eol_c ? sub_c : eoc_c ? '0 : sub_c + 1'b1;
      crow_d = !(eol_c && eoc_c) ? crow_c : eof_c ? '0 : crow_c + 1'b1;
      done_c = eoc_c && beat_c[0];
      last_c = done_c && eol_c && eof_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_q <= '0;
         sub_q  <= '0;
         crow_q <= '0;
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
      end else begin
         s1_v_q <= bus.in_valid;
         s2_v_q <= s1_v_q && !sof_c;
         if (bus.in_valid) begin
            beat_q <= beat_d;
            sub_q  <= sub_d;
            crow_q <= crow_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         s1_col_q  <= 5'(beat_c >> 1);
         s1_row_q  <= crow_c;
         s1_done_q <= done_c;
         s1_last_q <= last_c;
         s1_gx_q   <= gx_c;
         s1_gy_q   <= gy_c;
      end
      s2_col_q  <= s1_col_q;
      s2_row_q  <= s1_row_q;
      s2_done_q <= s1_done_q;
      s2_last_q <= s1_last_q;
      s2_mag_q  <= mag_c;
      s2_bin_q  <= bin_c;
   end

   // per-bin sum of this beat's four pixels, merged with the cell accumulator
   always_comb begin
      for (int b = 0; b < NBINS; b++) begin
         add_c[b] = '0;
         for (int p = 0; p < 4; p++)
            add_c[b] = add_c[b] + ((s2_bin_q[p] == bin_t'(b)) ? AW'(s2_mag_q[p]) : AW'(0));
         sum_c[b] = SUMW'(acc_q[s2_col_q][b]) + SUMW'(add_c[b]);
         new_c[b] = sum_c[b][HIST_W] ? '1 : sum_c[b][HIST_W-1:0];
      end
      emit_c = s2_v_q && s2_done_q && !sof_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         hist_q <= '0;
         ov_q   <= 1'b0;
         fd_q   <= 1'b0;
         ocol_q <= '0;
         orow_q <= '0;
      end else begin
         ov_q <= emit_c;
         fd_q <= emit_c && s2_last_q;
         if (sof_c) acc_q <= '0;
         else if (s2_v_q) acc_q[s2_col_q] <= s2_done_q ? '0 : new_c;
         if (emit_c) begin
            hist_q <= new_c;
            ocol_q <= s2_col_q;
            orow_q <= s2_row_q;
         end
      end
   end

   assign bus.out_valid  = ov_q;
   assign bus.frame_done = fd_q;
   assign bus.hist_out   = hist_q;
   assign bus.cell_col   = ocol_q;
   assign bus.cell_row   = orow_q;
endmodule

// File: tb/tb_hog_cell_hist.sv
// tb_hog_cell_hist: directed patterns with hand-computed cell histograms and output timing
module tb_hog_cell_hist;
   import hog_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hog_cell_hist_if #(.BITWIDTH(8), .HIST_W(16)) bus ();
   hog_cell_hist dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int due;
      int col;
      int row;
      logic last;
      logic [143:0] hist;
   } exp_t;

   exp_t q[$];
   int cyc = 0, n_cmp = 0, n_err = 0, n_out = 0, n_fd = 0, first_cyc = -1, mb = 0, mr = 0, c0 = 0;
   logic [143:0] exp_hist = '0;
   logic [71:0] flat, gx20, gxm20, gy40, gym40, d45, tie, mix8;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [71:0] mkblk(input logic [7:0] p1, p3, p5, p7);
      logic [71:0] b = {9{8'h80}};
      b[8 +: 8]  = p1;
      b[24 +: 8] = p3;
      b[40 +: 8] = p5;
      b[56 +: 8] = p7;
      return b;
   endfunction

   function automatic logic [143:0] h1(input int b, input int v);
      logic [143:0] h = '0;
      h[16*b +: 16] = 16'(v);
      return h;
   endfunction

   always @(negedge clk) begin
      if (bus.frame_done) chk("fd_with_ov", bus.out_valid, 1'b1);
      if (bus.out_valid) begin
         exp_t e;
         n_out++;
         if (bus.frame_done) n_fd++;
         if (first_cyc < 0) first_cyc = cyc;
         if (q.size() == 0) chk("spurious_ov", bus.out_valid, 1'b0);
         else begin
            e = q.pop_front();
            chk("ov_cycle", cyc, e.due);
            chk("cell_col", bus.cell_col, e.col);
            chk("cell_row", bus.cell_row, e.row);
            chk("hist", bus.hist_out, e.hist);
            chk("frame_done", bus.frame_done, e.last);
         end
      end else if (q.size() > 0 && cyc > q[0].due) begin
         chk("ov_missing", bus.out_valid, 1'b1);
         void'(q.pop_front());
      end
   end

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      rst_n = 1'b0;
      q.delete();
      mb = 0;
      mr = 0;
      @(posedge clk);
      #1;
      chk("rst_ov", bus.out_valid, 1'b0);
      chk("rst_fd", bus.frame_done, 1'b0);
      chk("rst_hist", bus.hist_out, '0);
      chk("rst_col", bus.cell_col, '0);
      chk("rst_row", bus.cell_row, '0);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [71:0] b0, b1, b2, b3, input logic sof);
      if (sof) begin
         mb = 0;
         mr = 0;
      end
      bus.in_valid = 1'b1;
      bus.in_sof = sof;
      bus.block0 = b0;
      bus.block1 = b1;
      bus.block2 = b2;
      bus.block3 = b3;
      if (mr % 8 == 7 && mb % 2 == 1)
         q.push_back('{due: cyc + 3, col: mb / 2, row: mr / 8, last: (mb == 51 && mr == 159), hist: exp_hist});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      mb++;
      if (mb == 52) begin
         mb = 0;
         mr = (mr == 159) ? 0 : mr + 1;
      end
   endtask

   task automatic beats(input int n, input logic [71:0] b0, b1, b2, b3, input logic sof, input logic gap);
      for (int i = 0; i < n; i++) begin
         send(b0, b1, b2, b3, sof && i == 0);
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      flat  = mkblk(8'h80, 8'h80, 8'h80, 8'h80);
      gx20  = mkblk(8'd50, 8'd10, 8'd30, 8'd50);
      gxm20 = mkblk(8'd50, 8'd30, 8'd10, 8'd50);
      gy40  = mkblk(8'd0, 8'd0, 8'd0, 8'd40);
      gym40 = mkblk(8'd40, 8'd0, 8'd0, 8'd0);
      d45   = mkblk(8'd0, 8'd0, 8'd10, 8'd10);
      tie   = mkblk(8'd0, 8'd0, 8'd255, 8'd93);
      bus.block0 = '0;
      bus.block1 = '0;
      bus.block2 = '0;
      bus.block3 = '0;
      do_reset();

      // full flat frame: 520 zero histograms, frame_done on cell (25,19)
      exp_hist = '0;
      n_out = 0;
      n_fd = 0;
      first_cyc = -1;
      c0 = cyc;
      beats(52 * 160, flat, flat, flat, flat, 1'b1, 1'b0);
      drain();
      chk("t1_first_lat", first_cyc - c0, 368);
      chk("t1_pulses", n_out, 520);
      chk("t1_fd_count", n_fd, 1);

      do_reset();
      exp_hist = h1(0, 1280);
      beats(416, gx20, gx20, gx20, gx20, 1'b1, 1'b0);
      drain();

      do_reset();
      exp_hist = h1(8, 1280);
      beats(416, gxm20, gxm20, gxm20, gxm20, 1'b1, 1'b0);
      drain();

      do_reset();
      exp_hist = h1(4, 2560);
      beats(416, gy40, gy40, gy40, gy40, 1'b1, 1'b0);
      drain();

      do_reset();
      exp_hist = h1(4, 2560);
      beats(416, gym40, gym40, gym40, gym40, 1'b1, 1'b0);
      drain();

      do_reset();
      exp_hist = h1(2, 1280);
      beats(416, d45, d45, d45, d45, 1'b1, 1'b0);
      drain();

      // gx=255, gy=93: 93*256 >= 93*255 but < 215*255 -> bin1, mag 348
      do_reset();
      exp_hist = h1(1, 22272);
      beats(416, tie, tie, tie, tie, 1'b1, 1'b0);
      drain();

      // four different bins in one beat
      do_reset();
      exp_hist = h1(0, 320) | h1(8, 320) | h1(4, 640) | h1(2, 320);
      beats(416, gx20, gxm20, gy40, d45, 1'b1, 1'b0);
      drain();

      do_reset();
      exp_hist = h1(0, 1280);
      beats(416, gx20, gx20, gx20, gx20, 1'b1, 1'b1);
      drain();

      // in_sof mid row 3 discards the partial bin4 cells and in-flight beats
      do_reset();
      beats(3 * 52 + 10, gy40, gy40, gy40, gy40, 1'b1, 1'b0);
      exp_hist = h1(0, 1280);
      beats(416, gx20, gx20, gx20, gx20, 1'b1, 1'b0);
      drain();

      // reset mid row 3, then a new frame without in_sof
      do_reset();
      beats(3 * 52 + 10, gy40, gy40, gy40, gy40, 1'b1, 1'b0);
      do_reset();
      exp_hist = h1(0, 1280);
      beats(416, gx20, gx20, gx20, gx20, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
